// File: rtl/uart_rx_fifo.sv
// UART receiver with glitch-rejecting start detection, configurable frame format,
// per-character error flags and a valid/ready output FIFO.

module uart_rx_fifo #(
   parameter int CLK_RATE   = 25000000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          ser_rx,
   output logic [DATA_BITS-1:0]          out_data,
   output logic                          out_parity_err,
   output logic                          out_frame_err,
   output logic                          out_break,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic                          busy
);

   localparam int DIV     = CLK_RATE / BAUD_RATE;
   localparam int HALF    = DIV / 2;
   localparam int CNT_W   = $clog2(DIV);
   localparam int BIT_W   = $clog2(DATA_BITS);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = DATA_BITS + 3;

   localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
   localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
   localparam logic             PAR_ODD   = (PARITY == 1) ? 1'b1 : 1'b0;
   localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   DEPTH_L   = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   logic                 sync1_q;
   logic                 sync2_q;
   logic                 armed_q;
   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [BIT_W-1:0]     bitCnt_q;
   logic                 stopCnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 parBit_q;
   logic                 parErr_q;
   logic                 frameErr_q;
   logic                 busy_q;

   logic                 rxBit;
   logic                 tick;
   logic                 lastStop;
   logic                 frameErrNow;
   logic                 breakNow;
   logic [ENTRY_W-1:0]   pushEntry;

   logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W:0]       wrPtr_q;
   logic [PTR_W:0]       rdPtr_q;
   logic [PTR_W:0]       wrPtr_d;
   logic [PTR_W:0]       rdPtr_d;
   logic                 overflow_q;
   logic                 overflow_d;
   logic [PTR_W:0]       level;
   logic                 empty;
   logic                 full;
   logic                 pop;
   logic                 push;
   logic [ENTRY_W-1:0]   headEntry;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= ser_rx;
         sync2_q <= sync1_q;
      end
   end

   assign rxBit    = sync2_q;
   assign tick     = (cnt_q == '0);
   assign lastStop = (state_q == STOP) && tick && (stopCnt_q == STOP_LAST);

   assign frameErrNow = frameErr_q | ~rxBit;
   assign breakNow    = frameErrNow & (shift_q == '0) & ~parBit_q;
   assign pushEntry   = {shift_q, parErr_q, frameErrNow, breakNow};

   // armed_q remembers that the line has been high since the last start, so a
   // line held low after a break cannot launch another frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         armed_q    <= 1'b0;
         cnt_q      <= '0;
         bitCnt_q   <= '0;
         stopCnt_q  <= 1'b0;
         shift_q    <= '0;
         parBit_q   <= 1'b0;
         parErr_q   <= 1'b0;
         frameErr_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         if (rxBit) begin
            armed_q <= 1'b1;
         end
         if (!tick) begin
            cnt_q <= cnt_q - CNT_ONE;
         end
         case (state_q)
            IDLE: begin
               if (armed_q && !rxBit) begin
                  state_q    <= START;
                  armed_q    <= 1'b0;
                  cnt_q      <= HALF_M1;
                  bitCnt_q   <= '0;
                  stopCnt_q  <= 1'b0;
                  parBit_q   <= 1'b0;
                  parErr_q   <= 1'b0;
                  frameErr_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (rxBit) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DATA;
                     cnt_q   <= DIV_M1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  shift_q <= {rxBit, shift_q[DATA_BITS-1:1]};
                  cnt_q   <= DIV_M1;
                  if (bitCnt_q == BIT_LAST) begin
                     state_q <= (PARITY != 0) ? PAR : STOP;
                  end else begin
                     bitCnt_q <= bitCnt_q + BIT_ONE;
                  end
               end
            end
            PAR: begin
               if (tick) begin
                  parBit_q <= rxBit;
                  parErr_q <= (((^shift_q) ^ rxBit) != PAR_ODD);
                  cnt_q    <= DIV_M1;
                  state_q  <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  if (!rxBit) begin
                     frameErr_q <= 1'b1;
                  end
                  cnt_q <= DIV_M1;
                  if (stopCnt_q == STOP_LAST) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     stopCnt_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign level = wrPtr_q - rdPtr_q;
   assign empty = (level == '0);
   assign full  = (level == DEPTH_L);

   // A push into a full FIFO still succeeds when the head is retired in the same cycle.
   always_comb begin
      pop        = ~empty & out_ready;
      push       = lastStop & (~full | pop);
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      overflow_d = overflow_q;
      if (push) begin
         wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + PTR_ONE;
      end
      if (lastStop && full && !pop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q[PTR_W-1:0]] <= pushEntry;
      end
   end

   assign headEntry = empty ? '0 : mem_q[rdPtr_q[PTR_W-1:0]];

   assign out_data       = headEntry[ENTRY_W-1:3];
   assign out_parity_err = headEntry[2];
   assign out_frame_err  = headEntry[1];
   assign out_break      = headEntry[0];
   assign out_valid      = ~empty;
   assign fifo_level     = level;
   assign overflow       = overflow_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance at DIV=10,
// expected entries queued at stimulus time and checked by per-instance monitors.

module tb_uart_rx_fifo;

   localparam int DIV = 10;

   logic       clk;
   logic       reset_n;

   logic       serN, readyN, clrOvf;
   logic [7:0] nData;
   logic       nPerr, nFerr, nBrk, nValid, nOvf, nBusy;
   logic [2:0] nLevel;

   logic       serE, readyE, clrE;
   logic [7:0] eData;
   logic       ePerr, eFerr, eBrk, eValid, eOvf, eBusy;
   logic [2:0] eLevel;

   int total = 0;
   int bad   = 0;

   logic [10:0] expN[$];
   logic [10:0] expE[$];

   uart_rx_fifo #(
      .CLK_RATE(25000000), .BAUD_RATE(2500000), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) u_n (
      .clk(clk), .reset_n(reset_n), .ser_rx(serN),
      .out_data(nData), .out_parity_err(nPerr), .out_frame_err(nFerr),
      .out_break(nBrk), .out_valid(nValid), .out_ready(readyN),
      .fifo_level(nLevel), .overflow(nOvf), .clr_overflow(clrOvf), .busy(nBusy)
   );

   uart_rx_fifo #(
      .CLK_RATE(25000000), .BAUD_RATE(2500000), .DATA_BITS(8),
      .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) u_e (
      .clk(clk), .reset_n(reset_n), .ser_rx(serE),
      .out_data(eData), .out_parity_err(ePerr), .out_frame_err(eFerr),
      .out_break(eBrk), .out_valid(eValid), .out_ready(readyE),
      .fifo_level(eLevel), .overflow(eOvf), .clr_overflow(clrE), .busy(eBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Drives n line bits LSB first, each held for one bit time; call from a negedge.
   task automatic applyStimulus(input bit toE, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (toE) serE = bits[i];
         else     serN = bits[i];
         repeat (DIV) @(negedge clk);
      end
   endtask

   function automatic logic [15:0] frameN(input logic [7:0] d, input logic stopBit);
      return {6'b0, stopBit, d, 1'b0};
   endfunction

   function automatic logic [15:0] frameE(input logic [7:0] d, input logic parBit, input logic stopBit);
      return {5'b0, stopBit, parBit, d, 1'b0};
   endfunction

   // Entries are retired on the posedge following a negedge where valid & ready hold.
   always @(negedge clk) begin
      #1;
      if (reset_n && nValid && readyN) begin
         if (expN.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL n_unexpected: got 0x%0h, want no entry", {nData, nPerr, nFerr, nBrk});
         end else begin
            checkOutput("n_entry", {nData, nPerr, nFerr, nBrk}, expN.pop_front());
         end
      end
      if (reset_n && eValid && readyE) begin
         if (expE.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL e_unexpected: got 0x%0h, want no entry", {eData, ePerr, eFerr, eBrk});
         end else begin
            checkOutput("e_entry", {eData, ePerr, eFerr, eBrk}, expE.pop_front());
         end
      end
   end

   initial begin
      serN = 1'b1; serE = 1'b1; readyN = 1'b0; readyE = 1'b1;
      clrOvf = 1'b0; clrE = 1'b0; reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_valid", nValid, 0);
      checkOutput("rst_level", nLevel, 0);
      checkOutput("rst_ovf", nOvf, 0);
      checkOutput("rst_busy", nBusy, 0);
      checkOutput("rst_data", {nData, nPerr, nFerr, nBrk}, 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // 0x41 with latency: stop sample lands on the 97th edge after the start bit.
      expN.push_back({8'h41, 3'b000});
      fork
         applyStimulus(0, frameN(8'h41, 1'b1), 10);
         begin
            repeat (97) @(negedge clk);
            checkOutput("a41_valid_before", nValid, 0);
            checkOutput("a41_busy_before", nBusy, 1);
            @(negedge clk);
            checkOutput("a41_valid_after", nValid, 1);
            checkOutput("a41_busy_after", nBusy, 0);
            checkOutput("a41_level", nLevel, 1);
         end
      join
      readyN = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("a41_drained", nValid, 0);

      // Short glitch is a false start.
      serN = 1'b0;
      repeat (3) @(negedge clk);
      serN = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("glitch_busy", nBusy, 1);
      repeat (3) @(negedge clk);
      checkOutput("glitch_idle", nBusy, 0);
      repeat (30) @(negedge clk);
      checkOutput("glitch_level", nLevel, 0);
      checkOutput("glitch_ovf", nOvf, 0);

      // Break: exactly one entry while the line stays low.
      expN.push_back({8'h00, 3'b011});
      serN = 1'b0;
      repeat (30 * DIV) @(negedge clk);
      checkOutput("brk_busy", nBusy, 0);
      checkOutput("brk_level", nLevel, 0);
      checkOutput("brk_one_entry", expN.size(), 0);
      serN = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      expN.push_back({8'h5A, 3'b000});
      applyStimulus(0, frameN(8'h5A, 1'b1), 10);

      // Low stop bit on non-zero data: frame error without break.
      expN.push_back({8'h41, 3'b010});
      applyStimulus(0, frameN(8'h41, 1'b0), 10);
      serN = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      checkOutput("ferr_level", nLevel, 0);

      // Overflow: five characters into a depth-4 FIFO.
      readyN = 1'b0;
      for (int d = 1; d <= 5; d++) begin
         if (d <= 4) expN.push_back({8'(d), 3'b000});
         applyStimulus(0, frameN(8'(d), 1'b1), 10);
      end
      repeat (5) @(negedge clk);
      checkOutput("ovf_level", nLevel, 4);
      checkOutput("ovf_set", nOvf, 1);
      clrOvf = 1'b1;
      @(negedge clk);
      clrOvf = 1'b0;
      checkOutput("ovf_clr", nOvf, 0);

      expN.push_back({8'h05, 3'b000});
      fork
         applyStimulus(0, frameN(8'h05, 1'b1), 10);
         begin
            repeat (97) @(negedge clk);
            readyN = 1'b1;
            @(negedge clk);
            readyN = 1'b0;
         end
      join
      checkOutput("popPush_level", nLevel, 4);
      checkOutput("popPush_ovf", nOvf, 0);

      fork
         applyStimulus(0, frameN(8'h77, 1'b1), 10);
         begin
            repeat (97) @(negedge clk);
            clrOvf = 1'b1;
            @(negedge clk);
            clrOvf = 1'b0;
         end
      join
      checkOutput("setWins_ovf", nOvf, 1);
      checkOutput("setWins_level", nLevel, 4);
      readyN = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("drain_level", nLevel, 0);
      clrOvf = 1'b1;
      @(negedge clk);
      clrOvf = 1'b0;

      // Reset in the middle of 0x7E with one stale entry waiting.
      readyN = 1'b0;
      applyStimulus(0, frameN(8'h33, 1'b1), 10);
      repeat (3) @(negedge clk);
      checkOutput("pre_rst_level", nLevel, 1);
      applyStimulus(0, frameN(8'h7E, 1'b1), 4);
      checkOutput("mid_rst_busy", nBusy, 1);
      reset_n = 1'b0;
      serN = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_level", nLevel, 0);
      checkOutput("mid_rst_valid", nValid, 0);
      checkOutput("mid_rst_busy0", nBusy, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      checkOutput("post_rst_level", nLevel, 0);
      checkOutput("post_rst_busy", nBusy, 0);
      readyN = 1'b1;
      expN.push_back({8'h7E, 3'b000});
      applyStimulus(0, frameN(8'h7E, 1'b1), 10);
      repeat (5) @(negedge clk);

      // Even parity instance.
      expE.push_back({8'h55, 3'b100});
      applyStimulus(1, frameE(8'h55, 1'b1, 1'b1), 11);
      expE.push_back({8'h55, 3'b000});
      applyStimulus(1, frameE(8'h55, 1'b0, 1'b1), 11);
      expE.push_back({8'h07, 3'b000});
      applyStimulus(1, frameE(8'h07, 1'b1, 1'b1), 11);
      expE.push_back({8'h07, 3'b100});
      applyStimulus(1, frameE(8'h07, 1'b0, 1'b1), 11);
      expE.push_back({8'h00, 3'b011});
      applyStimulus(1, frameE(8'h00, 1'b0, 1'b0), 11);
      serE = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      checkOutput("e_level", eLevel, 0);
      checkOutput("e_ovf", eOvf, 0);

      checkOutput("n_all_seen", expN.size(), 0);
      checkOutput("e_all_seen", expE.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Synthesisable, parametrised UART receiver with glitch-rejecting start detection, configurable frame format, per-character error flags and a buffered output FIFO with valid/ready handshake. It replaces the behavioural serial monitor in simulation benches and serves as the host-command receive path in the SoC. Characters are sampled at bit centres from a free-running system clock and queued for a downstream consumer.

## Interface
- CLK_RATE, 25000000, system clock frequency in Hz
- BAUD_RATE, 115200, line rate; DIV = CLK_RATE/BAUD_RATE (integer division, must be ≥ 4); HALF = DIV/2
- DATA_BITS, 8, data bits per character, 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 4, power of two, ≥ 2
- clk  in  1  system clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- ser_rx  in  1  asynchronous serial line, idle high
- out_data  out  DATA_BITS  head-of-FIFO character, LSB = first received bit
- out_parity_err  out  1  parity mismatch flag for head character (0 when PARITY = 0)
- out_frame_err  out  1  a stop bit sampled low for head character
- out_break  out  1  head character is a break (all data bits 0, parity bit 0 if present, frame error)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head entry when out_valid & out_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a character was dropped because the FIFO was full
- clr_overflow  in  1  synchronous clear of overflow
- busy  out  1  receiver FSM not in IDLE

## Operation
- ser_rx passes through a 2-flop synchroniser; both flops reset to 1.
- Arming: a start is recognised only on a synchronised 1→0 transition; a line held low (e.g. after break) never retriggers until it returns high.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE → START on a falling edge; bit counter loaded with HALF-1.
- START: at expiry, sample; 1 = false start → IDLE (nothing pushed); 0 → DATA, counter loaded with DIV-1.
- DATA: sample at each expiry, shift in LSB first; after DATA_BITS samples → PAR if PARITY ≠ 0, else STOP.
- PAR: sample; parity_err = (XOR of data ^ sampled bit) ≠ (PARITY == 1 ? 1 : 0).
- STOP: sample STOP_BITS times; any low sample sets frame_err. At final stop sample the entry {data, parity_err, frame_err, break} is pushed and FSM → IDLE in the same cycle, so a start edge immediately following is caught.
- FIFO push when full: entry dropped, overflow set. Simultaneous push and pop when full: both succeed, no overflow. Simultaneous set and clr_overflow: set wins.
- Pop on empty ignored. out_* fields are undefined-but-stable when out_valid = 0 (drive zeros).

## Timing
- Reset (async assert, sync-released by caller): all outputs 0, FSM IDLE, FIFO empty, overflow 0; a frame in progress is abandoned, nothing pushed.
- Synchroniser latency: 2 cycles. With ser_rx falling immediately before edge E0, the synchronised edge is seen at E2; start sample at E2+HALF; data bit k sample at E2+HALF+(k+1)·DIV.
- Push occurs on the final stop sample edge; out_valid and fifo_level update on that edge (visible the following cycle); empty-FIFO latency is 1 cycle after the sample.
- Pop: out_valid & out_ready at edge E retires the entry at E; next entry (or out_valid=0) is visible after E.
- busy high from the cycle after the falling edge is detected through the cycle of the final stop sample.

## Test plan
- CLK_RATE 25 MHz, BAUD 2.5 MHz (DIV=10), 8N1: send 0x41 → one entry 0x41, all error flags 0, out_valid 1 cycle after stop sample.
- Glitch: ser_rx low for 3 cycles then high → no push, busy returns 0 at start sample, overflow 0.
- PARITY=2, send 0x55 with parity bit 1 → out_parity_err=1, data 0x55; with parity bit 0 → no error.
- Break: hold ser_rx low for 30 bit times → exactly one entry, data 0, out_frame_err=1, out_break=1; no further entries until line high then new start.
- FIFO_DEPTH=4, out_ready=0, send 5 chars 0x01..0x05 → level 4, overflow=1, entries 0x01..0x04; clr_overflow clears; pop during 5th push with full FIFO → no overflow, 0x05 retained.
- Assert reset_n low mid-DATA of 0x7E → FIFO empty, no entry; next clean 0x7E received correctly.
